// File: rtl/gb_video_pkg.sv
// Shared Game Boy video definitions: LCD geometry, pixel type, capture states, error bit indices.
// No logic; no latency; no backpressure.
package gb_video_pkg;

  localparam int GB_LCD_W = 160;
  localparam int GB_LCD_H = 144;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_ACTIVE  = 2'd1,
    S_VBLANK  = 2'd2
  } cap_state_t;

  localparam int ERR_LINE  = 0;
  localparam int ERR_FRAME = 1;

endpackage

// File: rtl/gb_sync_edge.sv
// Multi-stage synchroniser followed by one alignment register; EDGE_MASK bits output rise pulses, others the level.
// Latency SYNC_STAGES+1 clk from pin to q; no backpressure.
module gb_sync_edge #(
  parameter int             W           = 1,
  parameter int             SYNC_STAGES = 2,
  parameter logic [W-1:0]   EDGE_MASK   = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync [SYNC_STAGES];
  logic [W-1:0] cur;
  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      cur  <= '0;
      prev <= '0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      cur  <= sync[SYNC_STAGES-1];
      prev <= cur;
    end
  end

  // Masked bits become rise = cur & ~prev; unmasked bits pass cur as a pure delay.
  assign q = cur & ~(prev & EDGE_MASK);

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the Game Boy LCD stream into framebuffer writes; double buffering via GB_LCD_CAPTURE_DBL_BUF_EN.
// fb_we asserts SYNC_STAGES+2 clk after the cpl rise on the pin; no backpressure (writes are fire-and-forget).
module gb_lcd_capture import gb_video_pkg::*; #(
  parameter int WIDTH       = GB_LCD_W,
  parameter int HEIGHT      = GB_LCD_H,
  parameter int AW          = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gb_hs,
  input  logic          gb_vs,
  input  logic          gb_cpl,
  input  logic [1:0]    gb_pdat,
  input  logic          gb_valid,
  input  logic          clr_err,
  output logic          fb_we,
  output logic [AW-1:0] fb_waddr,
  output logic [1:0]    fb_wdata,
  output logic          fb_bank,
  output logic [7:0]    line_cnt,
  output logic          frame_done,
  output logic [1:0]    err_flags
);

  localparam logic [7:0]    W8 = 8'(WIDTH);
  localparam logic [7:0]    H8 = 8'(HEIGHT);
  localparam logic [AW-1:0] WA = AW'(WIDTH);

  logic   hs_rise, vs_rise, cpl_rise, valid_s;
  pixel_t pdat_s;

  gb_sync_edge #(.W(4), .SYNC_STAGES(SYNC_STAGES), .EDGE_MASK(4'b0111)) u_ctl_sync (
    .clk (clk),
    .rst (rst),
    .d   ({gb_valid, gb_cpl, gb_vs, gb_hs}),
    .q   ({valid_s, cpl_rise, vs_rise, hs_rise})
  );

  gb_sync_edge #(.W(2), .SYNC_STAGES(SYNC_STAGES), .EDGE_MASK(2'b00)) u_pdat_dly (
    .clk (clk),
    .rst (rst),
    .d   (gb_pdat),
    .q   (pdat_s)
  );

  cap_state_t    state, state_nxt;
  logic [7:0]    x, x_nxt, x_cnt, y, y_nxt;
  logic [AW-1:0] line_base, base_nxt, waddr_nxt;
  pixel_t        wdata_nxt;
  logic          we_nxt, done_nxt;
  logic [1:0]    err_set;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    x_cnt     = x;
    y_nxt     = y;
    base_nxt  = line_base;
    we_nxt    = 1'b0;
    waddr_nxt = fb_waddr;
    wdata_nxt = fb_wdata;
    done_nxt  = 1'b0;
    err_set   = 2'b00;
    case (state)
      S_WAIT_VS: begin
        if (vs_rise) begin
          x_nxt     = '0;
          y_nxt     = '0;
          base_nxt  = '0;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vs_rise) begin
          err_set[ERR_FRAME] = 1'b1;
          x_nxt    = '0;
          y_nxt    = '0;
          base_nxt = '0;
        end else begin
          if (cpl_rise && valid_s) begin
            if (x < W8) begin
              we_nxt    = 1'b1;
              waddr_nxt = line_base + AW'(x);
              wdata_nxt = pdat_s;
              x_cnt     = x + 8'd1;
            end else begin
              err_set[ERR_LINE] = 1'b1;
            end
          end
          x_nxt = x_cnt;
          // A pixel arriving with hs is counted before the line length check.
          if (hs_rise) begin
            if (x_cnt != W8) err_set[ERR_LINE] = 1'b1;
            x_nxt    = '0;
            y_nxt    = y + 8'd1;
            base_nxt = line_base + WA;
            if (y_nxt == H8) state_nxt = S_VBLANK;
          end
        end
      end
      S_VBLANK: begin
        if (vs_rise) begin
          done_nxt  = 1'b1;
          x_nxt     = '0;
          y_nxt     = '0;
          base_nxt  = '0;
          state_nxt = S_ACTIVE;
        end
      end
      default: state_nxt = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_VS;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
      err_flags  <= '0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      line_base  <= base_nxt;
      fb_we      <= we_nxt;
      fb_waddr   <= waddr_nxt;
      fb_wdata   <= wdata_nxt;
      frame_done <= done_nxt;
      err_flags  <= (clr_err ? 2'b00 : err_flags) | err_set;
    end
  end

  assign line_cnt = y;

`ifdef GB_LCD_CAPTURE_DBL_BUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fb_bank <= 1'b0;
    else if (done_nxt) fb_bank <= ~fb_bank;
  end
`else
  assign fb_bank = 1'b0;
`endif

endmodule
